// File: rtl/hash_byte_serializer.sv
// rtl/hash_byte_serializer.sv - buffers 128-bit hash words and emits them as a valid/ready byte stream
// Optional HASH_SER_FRAME_EN wraps each word as 0xA5, 16 payload bytes, XOR checksum.
module hash_byte_serializer #(
   parameter int DEPTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   input  logic [127:0]             i_hash,
   output logic                     o_valid,
   output logic [7:0]               o_data,
   input  logic                     i_ready,
   output logic                     o_overflow,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

`ifdef HASH_SER_FRAME_EN
   typedef enum logic [1:0] {IDLE, SEND, HDR, CHK} state_t;
`else
   typedef enum logic {IDLE, SEND} state_t;
`endif

   state_t       state;
   logic [127:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr, count;
   logic [3:0]   cnt;
   logic [127:0] head;
   logic         full, empty, xfer, last, pop, push, more;

   function automatic logic [7:0] byte_sel(input logic [127:0] w, input logic [3:0] idx);
      int b;
      b = MSB_FIRST ? 15 - int'(idx) : int'(idx);
      return w[b*8 +: 8];
   endfunction

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == LVL_FULL);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr[AW-1:0]];
   assign xfer  = o_valid & i_ready;
`ifdef HASH_SER_FRAME_EN
   assign last  = (state == CHK);
`else
   assign last  = (state == SEND) && (cnt == 4'd15);
`endif
   assign pop   = xfer & last;
   assign push  = i_valid & (~full | pop);
   // Something remains to send after this pop: an older word or the one arriving now.
   assign more  = (count > LVL_ONE) | push;

   assign o_level = count;
   assign o_busy  = (state != IDLE);

`ifdef HASH_SER_FRAME_EN
   logic [7:0] chk;
`else
   logic [AW-1:0] rd_next;
   logic [127:0]  next_head;
   assign rd_next   = rd_ptr[AW-1:0] + AW'(1);
   // With a single word held, the follower can only be the word being pushed this cycle.
   assign next_head = (count > LVL_ONE) ? mem[rd_next] : i_hash;
`endif

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= i_hash;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + LVL_ONE;
         if (pop)
            rd_ptr <= rd_ptr + LVL_ONE;
         if (i_valid && full && !pop)
            o_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         o_valid <= 1'b0;
         o_data  <= 8'h00;
`ifdef HASH_SER_FRAME_EN
         chk     <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  o_valid <= 1'b1;
                  cnt     <= 4'd0;
`ifdef HASH_SER_FRAME_EN
                  state   <= HDR;
                  o_data  <= 8'hA5;
`else
                  state   <= SEND;
                  o_data  <= byte_sel(head, 4'd0);
`endif
               end
            end
            SEND: begin
               if (xfer) begin
                  cnt <= cnt + 4'd1;
`ifdef HASH_SER_FRAME_EN
                  chk <= chk ^ o_data;
                  if (cnt == 4'd15) begin
                     state  <= CHK;
                     o_data <= chk ^ o_data;
                  end else begin
                     o_data <= byte_sel(head, cnt + 4'd1);
                  end
`else
                  if (cnt != 4'd15) begin
                     o_data <= byte_sel(head, cnt + 4'd1);
                  end else if (more) begin
                     o_data <= byte_sel(next_head, 4'd0);
                  end else begin
                     state   <= IDLE;
                     o_valid <= 1'b0;
                     o_data  <= 8'h00;
                  end
`endif
               end
            end
`ifdef HASH_SER_FRAME_EN
            HDR: begin
               if (xfer) begin
                  state  <= SEND;
                  cnt    <= 4'd0;
                  chk    <= 8'h00;
                  o_data <= byte_sel(head, 4'd0);
               end
            end
            CHK: begin
               if (xfer) begin
                  if (more) begin
                     state  <= HDR;
                     o_data <= 8'hA5;
                  end else begin
                     state   <= IDLE;
                     o_valid <= 1'b0;
                     o_data  <= 8'h00;
                  end
               end
            end
`endif
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_data  <= 8'h00;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_hash_byte_serializer.sv
// tb/tb_hash_byte_serializer.sv - randomized bench for hash_byte_serializer against a word-queue model
module tb_hash_byte_serializer;
   localparam int DEPTH = 4;
`ifdef HASH_SER_FRAME_EN
   localparam int FR = 18;
`else
   localparam int FR = 16;
`endif

   logic         clk = 1'b0;
   logic         rst, i_valid, i_ready;
   logic [127:0] i_hash;
   logic         o_valid, o_overflow, o_busy;
   logic [7:0]   o_data;
   logic [2:0]   o_level;

   int checks = 0;
   int errors = 0;

   logic [127:0] wq[$];
   int           bi;
   bit           m_send, m_ovf;

   always #5 clk = ~clk;

   hash_byte_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_hash     (i_hash),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .i_ready    (i_ready),
      .o_overflow (o_overflow),
      .o_level    (o_level),
      .o_busy     (o_busy)
   );

   function automatic logic [7:0] frame_byte(input logic [127:0] w, input int i);
      logic [7:0] x;
      int j;
      x = 8'h00;
      j = i;
`ifdef HASH_SER_FRAME_EN
      if (i == 0) return 8'hA5;
      if (i == FR - 1) begin
         for (int k = 0; k < 16; k++) x ^= 8'(w >> (8 * k));
         return x;
      end
      j = i - 1;
`endif
      return 8'(w >> (8 * (15 - j)));
   endfunction

   function automatic logic [7:0] m_byte();
      if (m_send && wq.size() > 0) return frame_byte(wq[0], bi);
      return 8'h00;
   endfunction

   function automatic logic [13:0] obs();
      return {o_valid, o_data, o_level, o_overflow, o_busy};
   endfunction

   function automatic logic [13:0] mexp();
      return {m_send, m_byte(), 3'(wq.size()), m_ovf, m_send};
   endfunction

   // Apply inputs for one edge, then advance the word-level model across that edge.
   task automatic step(input bit r, input bit v, input logic [127:0] h, input bit rdy);
      bit xfer, lst, was_full, was_nonempty;
      rst = r; i_valid = v; i_hash = h; i_ready = rdy;
      @(posedge clk);
      #1;
      if (r) begin
         wq.delete(); bi = 0; m_send = 0; m_ovf = 0;
      end else begin
         was_nonempty = (wq.size() > 0);
         was_full     = (wq.size() == DEPTH);
         xfer = m_send && rdy;
         lst  = xfer && (bi == FR - 1);
         if (xfer) bi++;
         if (lst) begin
            void'(wq.pop_front());
            bi = 0;
         end
         if (v) begin
            if (!was_full || lst) wq.push_back(h);
            else m_ovf = 1;
         end
         if (!m_send) m_send = was_nonempty;
         else if (lst) m_send = (wq.size() > 0);
      end
   endtask

   function automatic logic [127:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic test_reset;
      step(1, 0, '0, 0);
      checks++;
      if (obs() !== 14'h0) begin
         errors++;
         $display("FAIL reset: got %h expected %h", obs(), 14'h0);
      end
   endtask

   task automatic test_single;
      logic [127:0] w = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      logic [7:0]   got[$];
      logic [7:0]   exp_b;
      step(1, 0, '0, 1);
      step(0, 1, w, 1);
      checks++;
      if (o_valid !== 1'b0 || o_level !== 3'd1) begin
         errors++;
         $display("FAIL single_push: got v=%b lvl=%0d expected v=0 lvl=1", o_valid, o_level);
      end
      for (int c = 0; c < FR + 3; c++) begin
         if (o_valid) got.push_back(o_data);
         step(0, 0, '0, 1);
         checks++;
         if (obs() !== mexp()) begin
            errors++;
            $display("FAIL single_cycle%0d: got %h expected %h", c, obs(), mexp());
         end
      end
      checks++;
      if (got.size() != FR) begin
         errors++;
         $display("FAIL single_count: got %0d expected %0d", got.size(), FR);
      end
      for (int k = 0; k < got.size() && k < FR; k++) begin
`ifdef HASH_SER_FRAME_EN
         exp_b = frame_byte(w, k);
`else
         exp_b = 8'(k * 17);
`endif
         checks++;
         if (got[k] !== exp_b) begin
            errors++;
            $display("FAIL single_byte%0d: got %h expected %h", k, got[k], exp_b);
         end
      end
      checks++;
      if (o_valid !== 1'b0 || o_level !== 3'd0) begin
         errors++;
         $display("FAIL single_end: got v=%b lvl=%0d expected v=0 lvl=0", o_valid, o_level);
      end
   endtask

   task automatic test_backpressure;
      logic [127:0] w = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      logic [7:0]   got[$];
      bit           rdy, prev_stall;
      logic [7:0]   prev_d;
      step(1, 0, '0, 0);
      step(0, 1, w, 0);
      prev_stall = 0;
      prev_d = 8'h00;
      for (int c = 0; c < 2 * FR + 8; c++) begin
         rdy = (c % 4 == 0) || (c % 4 == 3);
         if (o_valid && rdy) got.push_back(o_data);
         prev_stall = o_valid && !rdy;
         prev_d = o_data;
         step(0, 0, '0, rdy);
         checks++;
         if (obs() !== mexp()) begin
            errors++;
            $display("FAIL bp_cycle%0d: got %h expected %h", c, obs(), mexp());
         end
         if (prev_stall) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== prev_d) begin
               errors++;
               $display("FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=%h", c, o_valid, o_data, prev_d);
            end
         end
      end
      checks++;
      if (got.size() != FR) begin
         errors++;
         $display("FAIL bp_count: got %0d expected %0d", got.size(), FR);
      end
      for (int k = 0; k < got.size() && k < FR; k++) begin
         checks++;
         if (got[k] !== frame_byte(w, k)) begin
            errors++;
            $display("FAIL bp_byte%0d: got %h expected %h", k, got[k], frame_byte(w, k));
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [127:0] w1, w2;
      logic [7:0]   got[$];
      int           first, lastc;
      w1 = rnd_word();
      w2 = rnd_word();
      first = -1;
      lastc = -1;
      step(1, 0, '0, 1);
      step(0, 1, w1, 1);
      step(0, 1, w2, 1);
      for (int c = 0; c < 2 * FR + 4; c++) begin
         if (o_valid) begin
            got.push_back(o_data);
            if (first < 0) first = c;
            lastc = c;
         end
         step(0, 0, '0, 1);
         checks++;
         if (obs() !== mexp()) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got %h expected %h", c, obs(), mexp());
         end
      end
      checks++;
      if (got.size() != 2 * FR || lastc - first + 1 != 2 * FR) begin
         errors++;
         $display("FAIL b2b_contig: got %0d bytes over %0d cycles expected %0d", got.size(), lastc - first + 1, 2 * FR);
      end
      for (int k = 0; k < got.size() && k < 2 * FR; k++) begin
         checks++;
         if (got[k] !== frame_byte(k < FR ? w1 : w2, k % FR)) begin
            errors++;
            $display("FAIL b2b_byte%0d: got %h expected %h", k, got[k], frame_byte(k < FR ? w1 : w2, k % FR));
         end
      end
   endtask

   task automatic test_overflow;
      logic [127:0] ws[5];
      logic [7:0]   got[$];
      step(1, 0, '0, 0);
      for (int n = 0; n < 5; n++) begin
         ws[n] = rnd_word();
         step(0, 1, ws[n], 0);
         checks++;
         if (obs() !== mexp()) begin
            errors++;
            $display("FAIL ovf_push%0d: got %h expected %h", n, obs(), mexp());
         end
      end
      checks++;
      if (o_level !== 3'd4 || o_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_state: got lvl=%0d ovf=%b expected lvl=4 ovf=1", o_level, o_overflow);
      end
      for (int c = 0; c < 4 * FR + 6; c++) begin
         if (o_valid) got.push_back(o_data);
         step(0, 0, '0, 1);
         checks++;
         if (obs() !== mexp()) begin
            errors++;
            $display("FAIL ovf_drain%0d: got %h expected %h", c, obs(), mexp());
         end
      end
      checks++;
      if (got.size() != 4 * FR || o_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_words: got %0d bytes ovf=%b expected %0d bytes ovf=1", got.size(), o_overflow, 4 * FR);
      end
      for (int k = 0; k < got.size() && k < 4 * FR; k++) begin
         checks++;
         if (got[k] !== frame_byte(ws[k / FR], k % FR)) begin
            errors++;
            $display("FAIL ovf_byte%0d: got %h expected %h", k, got[k], frame_byte(ws[k / FR], k % FR));
         end
      end
   endtask

   task automatic test_push_at_pop;
      bit done;
      done = 0;
      step(1, 0, '0, 0);
      for (int n = 0; n < 4; n++) step(0, 1, rnd_word(), 0);
      for (int c = 0; c < 6 * FR; c++) begin
         if (!done && m_send && bi == FR - 1) begin
            step(0, 1, rnd_word(), 1);
            done = 1;
            checks++;
            if (o_overflow !== 1'b0 || o_level !== 3'd4) begin
               errors++;
               $display("FAIL pop_push: got ovf=%b lvl=%0d expected ovf=0 lvl=4", o_overflow, o_level);
            end
         end else begin
            step(0, 0, '0, 1);
         end
         checks++;
         if (obs() !== mexp()) begin
            errors++;
            $display("FAIL pop_cycle%0d: got %h expected %h", c, obs(), mexp());
         end
      end
      checks++;
      if (!done || o_level !== 3'd0) begin
         errors++;
         $display("FAIL pop_drain: got done=%0d lvl=%0d expected done=1 lvl=0", done, o_level);
      end
   endtask

   task automatic test_reset_mid;
      logic [127:0] w2;
      logic [7:0]   got[$];
      logic [7:0]   exp_b;
      int           n;
      n = 0;
`ifdef HASH_SER_FRAME_EN
      w2 = {16{8'h01}};
`else
      w2 = rnd_word();
`endif
      step(1, 0, '0, 1);
      step(0, 1, rnd_word(), 1);
      step(0, 1, rnd_word(), 1);
      for (int c = 0; c < 30 && n < 8; c++) begin
         if (o_valid) n++;
         step(0, 0, '0, 1);
      end
      step(1, 0, '0, 1);
      checks++;
      if (n != 8 || o_valid !== 1'b0 || o_level !== 3'd0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_clear: got n=%0d v=%b lvl=%0d busy=%b expected n=8 v=0 lvl=0 busy=0", n, o_valid, o_level, o_busy);
      end
      step(0, 1, w2, 1);
      for (int c = 0; c < FR + 3; c++) begin
         if (o_valid) got.push_back(o_data);
         step(0, 0, '0, 1);
         checks++;
         if (obs() !== mexp()) begin
            errors++;
            $display("FAIL rstmid_cycle%0d: got %h expected %h", c, obs(), mexp());
         end
      end
      checks++;
      if (got.size() != FR) begin
         errors++;
         $display("FAIL rstmid_count: got %0d expected %0d", got.size(), FR);
      end
      for (int k = 0; k < got.size() && k < FR; k++) begin
`ifdef HASH_SER_FRAME_EN
         exp_b = (k == 0) ? 8'hA5 : (k == FR - 1) ? 8'h00 : 8'h01;
`else
         exp_b = 8'(w2 >> (8 * (15 - k)));
`endif
         checks++;
         if (got[k] !== exp_b) begin
            errors++;
            $display("FAIL rstmid_byte%0d: got %h expected %h", k, got[k], exp_b);
         end
      end
   endtask

   task automatic test_random;
      bit v, rdy;
      for (int seg = 0; seg < 3; seg++) begin
         step(1, 0, '0, 0);
         for (int c = 0; c < 400; c++) begin
            v   = ($urandom_range(0, 9 + 10 * seg) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(0, v, rnd_word(), rdy);
            checks++;
            if (obs() !== mexp()) begin
               errors++;
               $display("FAIL rand_s%0d_c%0d: got %h expected %h", seg, c, obs(), mexp());
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      i_valid = 1'b0;
      i_hash = '0;
      i_ready = 1'b0;
      bi = 0;
      m_send = 0;
      m_ovf = 0;
      test_reset;
      test_single;
      test_backpressure;
      test_back_to_back;
      test_overflow;
      test_push_at_pop;
      test_reset_mid;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hash_byte_serializer.md
Name: hash_byte_serializer

Overview:
- Sink for the validator's hash output stream.
- Accepts 128-bit hash words on a valid-only strobe (no backpressure on input) and buffers them in a small FIFO.
- Emits each word as 16 bytes on an 8-bit valid/ready stream toward the host link (UART/byte transport).
- Flags any word lost to overflow.

Parameters:
- DEPTH, 4, FIFO entries in 128-bit words; power of two, >= 2.
- MSB_FIRST, 1, 1: byte 0 sent = hash[127:120]; 0: byte 0 sent = hash[7:0].

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  hash word strobe, one word per cycle when high.
- i_hash  input  128  hash word, sampled when i_valid=1.
- o_valid  output  1  byte available on o_data.
- o_data  output  8  current output byte.
- i_ready  input  1  downstream accepts byte; transfer = o_valid & i_ready.
- o_overflow  output  1  sticky; set when a word is dropped.
- o_level  output  $clog2(DEPTH)+1  words held in FIFO, including the word in transmission.
- o_busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - Outputs: o_valid=0, o_data=0, o_overflow=0, o_level=0, o_busy=0.
  - FIFO pointers are cleared, FSM goes to IDLE, byte counter = 0.
  - Reset mid-word discards all buffered and partially sent data; no further bytes are emitted for that word.
- FIFO:
  - Circular buffer with pointers one bit wider than the index, so full and empty are unambiguous.
  - Push occurs when i_valid=1 and (not full, or a pop happens in the same cycle).
  - When full with no pop, the word is dropped and o_overflow is set, and stays set until rst.
  - Pop occurs on the transfer of the last byte (counter=15).
  - Simultaneous push and pop: o_level is unchanged.
- FSM states: IDLE and SEND (plus HDR/CHK when framing is enabled).
  - IDLE: if FIFO is not empty, go to SEND on the next edge with counter=0.
  - SEND:
    - o_valid=1.
    - o_data = head byte selected by the counter and MSB_FIRST.
    - Each transfer increments the counter.
    - At counter=15 with a transfer: if the FIFO still holds another word after the pop, stay in SEND with counter=0 (back-to-back words, no bubble); otherwise go to IDLE.
- Latency: a word pushed at edge N gives o_valid=1 with byte 0 after edge N+1, provided the FSM was IDLE.
- Handshake rules:
  - Once o_valid is high, o_valid and o_data hold stable until a transfer occurs.
  - i_ready may be low for arbitrarily long.
  - o_valid never depends combinationally on i_ready.
- Counter: 4 bits, wraps 15->0 only on a transfer.
- o_busy = (state != IDLE).

Optional Feature:
- Macro: HASH_SER_FRAME_EN.
- Defined:
  - Each word is framed as: header byte 0xA5 (state HDR), the 16 payload bytes (SEND), then a checksum byte (state CHK).
  - Checksum = XOR of the 16 payload bytes, 18 bytes total per word.
  - Pop occurs on the transfer of the CHK byte.
  - After CHK: go to HDR if the FIFO is not empty, else IDLE.
  - Latency from push to the first byte (0xA5) is unchanged.
- Undefined:
  - HDR and CHK states and the XOR logic are absent.
  - Raw 16-byte frames as described in Behaviour.

Test Plan:
- Single word: push 128'h00112233_44556677_8899AABB_CCDDEEFF, i_ready=1, MSB_FIRST=1 -> bytes 00,11,…,FF on 16 consecutive cycles starting 1 cycle after the push; then o_valid=0 and o_level=0.
- Backpressure: same word, i_ready toggled 1,0,0,1,… -> o_data holds while stalled; byte sequence identical; no byte duplicated or skipped.
- Back-to-back: 2 words pushed on consecutive cycles, i_ready=1 -> 32 contiguous bytes with no bubble between words; o_level goes 1,2,…,1,0.
- Overflow: DEPTH=4, i_ready=0, push 5 words -> o_level=4, o_overflow=1; release i_ready -> exactly the first 4 words emitted, 5th absent.
- Push at full during final-byte pop: FIFO full, push coincides with the counter=15 transfer -> word accepted, o_overflow stays 0, o_level stays 4.
- Reset mid-word: rst asserted after byte 7 -> next cycle o_valid=0, o_level=0; a new push restarts from byte 0. With HASH_SER_FRAME_EN: word of all 8'h01 -> A5, 16×01, checksum 00.
